pipe_ctrl: RTL and testbench

Pipelined control unit for the RV32I core. It decodes the instruction in ID, including loads and stores, and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, flushes on taken branches/jumps, freezes on a data-memory handshake, and keeps saturating stall/flush counters. It sits between the instruction fetch register and the EX/MEM/WB datapath, replacing the purely combinational decoder.

---
 rtl/pipe_ctrl_pkg.sv | 99 +++++++++
 rtl/pipe_ctrl_decode.sv | 142 ++++++++++++++
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared RV32I control encodings and the per-stage control bundle layout.
// A bubble is the all-zero bundle: ZERO, NONE and ALU are all encoded as 0.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_CTRL_ZERO  = 4'd0;
    localparam logic [3:0] ALU_CTRL_ADD   = 4'd1;
    localparam logic [3:0] ALU_CTRL_SUB   = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLL   = 4'd3;
    localparam logic [3:0] ALU_CTRL_SLT   = 4'd4;
    localparam logic [3:0] ALU_CTRL_SLTU  = 4'd5;
    localparam logic [3:0] ALU_CTRL_XOR   = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRL   = 4'd7;
    localparam logic [3:0] ALU_CTRL_SRA   = 4'd8;
    localparam logic [3:0] ALU_CTRL_OR    = 4'd9;
    localparam logic [3:0] ALU_CTRL_AND   = 4'd10;
    localparam logic [3:0] ALU_CTRL_PASSB = 4'd11;

    localparam logic [4:0] IMM_CTRL_NONE  = 5'b00000;
    localparam logic [4:0] IMM_CTRL_ITYPE = 5'b00001;
    localparam logic [4:0] IMM_CTRL_STYPE = 5'b00010;
    localparam logic [4:0] IMM_CTRL_BTYPE = 5'b00100;
    localparam logic [4:0] IMM_CTRL_UTYPE = 5'b01000;
    localparam logic [4:0] IMM_CTRL_JTYPE = 5'b10000;

    localparam logic [1:0] JUMP_TYPE_NONE = 2'd0;
    localparam logic [1:0] JUMP_TYPE_JAL  = 2'd1;
    localparam logic [1:0] JUMP_TYPE_JALR = 2'd2;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       branch;
        logic [2:0] branch_type;
        logic [1:0] jump_type;
    } ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_width;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] memto_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_bundle_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '{alu_ctrl: ALU_CTRL_ZERO, alu_src_a: 1'b0, alu_src_b: 1'b0,
                                         branch: 1'b0, branch_type: 3'b000, jump_type: JUMP_TYPE_NONE};
    localparam mem_ctrl_t MEM_BUBBLE = '{mem_read: 1'b0, mem_write: 1'b0, mem_width: 3'b000};
    localparam wb_ctrl_t  WB_BUBBLE  = '{reg_write: 1'b0, memto_reg: MEMTOREG_ALU};
    localparam ctrl_bundle_t CTRL_BUBBLE = '{ex: EX_BUBBLE, mem: MEM_BUBBLE, wb: WB_BUBBLE};

    // alt selects SUB/SRA; the caller decides when funct7 is allowed to mean that.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: alu_op = alt ? ALU_CTRL_SUB : ALU_CTRL_ADD;
            F3_SLL:     alu_op = ALU_CTRL_SLL;
            F3_SLT:     alu_op = ALU_CTRL_SLT;
            F3_SLTU:    alu_op = ALU_CTRL_SLTU;
            F3_XOR:     alu_op = ALU_CTRL_XOR;
            F3_SRL_SRA: alu_op = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
            F3_OR:      alu_op = ALU_CTRL_OR;
            default:    alu_op = ALU_CTRL_AND;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational RV32I decoder: instruction to control bundle, legality
// and register-use flags for the hazard unit.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int INSTR_SIZE = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit RV_E       = 1'b0
) (
    input  logic [INSTR_SIZE-1:0] instr,
    output ctrl_bundle_t          bundle,
    output logic [4:0]            imm_ctrl,
    output logic                  illegal,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  use_rs1,
    output logic                  use_rs2
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic       use_rd;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[7 +: REG_ADDR_W];
    assign rs1    = instr[15 +: REG_ADDR_W];
    assign rs2    = instr[20 +: REG_ADDR_W];

    always_comb begin
        bundle   = CTRL_BUBBLE;
        imm_ctrl = IMM_CTRL_NONE;
        legal    = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        case (opcode)
            OP_LUI: begin
                imm_ctrl               = IMM_CTRL_UTYPE;
                bundle.ex.alu_ctrl     = ALU_CTRL_PASSB;
                bundle.ex.alu_src_b    = 1'b1;
                bundle.wb.reg_write    = 1'b1;
            end
            OP_AUIPC: begin
                imm_ctrl               = IMM_CTRL_UTYPE;
                bundle.ex.alu_ctrl     = ALU_CTRL_ADD;
                bundle.ex.alu_src_a    = 1'b1;
                bundle.ex.alu_src_b    = 1'b1;
                bundle.wb.reg_write    = 1'b1;
            end
            OP_JAL: begin
                imm_ctrl               = IMM_CTRL_JTYPE;
                bundle.ex.alu_ctrl     = ALU_CTRL_ADD;
                bundle.ex.alu_src_a    = 1'b1;
                bundle.ex.alu_src_b    = 1'b1;
                bundle.ex.jump_type    = JUMP_TYPE_JAL;
                bundle.wb.reg_write    = 1'b1;
                bundle.wb.memto_reg    = MEMTOREG_PC4;
            end
            OP_JALR: begin
                legal                  = (f3 == F3_ADD_SUB);
                imm_ctrl               = IMM_CTRL_ITYPE;
                use_rs1                = 1'b1;
                bundle.ex.alu_ctrl     = ALU_CTRL_ADD;
                bundle.ex.alu_src_b    = 1'b1;
                bundle.ex.jump_type    = JUMP_TYPE_JALR;
                bundle.wb.reg_write    = 1'b1;
                bundle.wb.memto_reg    = MEMTOREG_PC4;
            end
            OP_BRANCH: begin
                legal                  = (f3 != F3_SLT) && (f3 != F3_SLTU);
                imm_ctrl               = IMM_CTRL_BTYPE;
                use_rs1                = 1'b1;
                use_rs2                = 1'b1;
                bundle.ex.alu_ctrl     = ALU_CTRL_SUB;
                bundle.ex.branch       = 1'b1;
                bundle.ex.branch_type  = f3;
            end
            OP_LOAD: begin
                legal                  = (f3 != F3_SLTU) && (f3[2:1] != 2'b11);
                imm_ctrl               = IMM_CTRL_ITYPE;
                use_rs1                = 1'b1;
                bundle.ex.alu_ctrl     = ALU_CTRL_ADD;
                bundle.ex.alu_src_b    = 1'b1;
                bundle.mem.mem_read    = 1'b1;
                bundle.mem.mem_width   = f3;
                bundle.wb.reg_write    = 1'b1;
                bundle.wb.memto_reg    = MEMTOREG_MEM;
            end
            OP_STORE: begin
                legal                  = (f3[2] == 1'b0) && (f3 != F3_SLTU);
                imm_ctrl               = IMM_CTRL_STYPE;
                use_rs1                = 1'b1;
                use_rs2                = 1'b1;
                bundle.ex.alu_ctrl     = ALU_CTRL_ADD;
                bundle.ex.alu_src_b    = 1'b1;
                bundle.mem.mem_write   = 1'b1;
                bundle.mem.mem_width   = f3;
            end
            OP_IMM: begin
                if (f3 == F3_SLL)          legal = (f7 == F7_BASE);
                else if (f3 == F3_SRL_SRA) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                imm_ctrl               = IMM_CTRL_ITYPE;
                use_rs1                = 1'b1;
                bundle.ex.alu_ctrl     = alu_op(f3, (f3 == F3_SRL_SRA) && (f7 == F7_ALT));
                bundle.ex.alu_src_b    = 1'b1;
                bundle.wb.reg_write    = 1'b1;
                bundle.wb.memto_reg    = MEMTOREG_ALU;
            end
            OP_REG: begin
                legal                  = (f7 == F7_BASE) ||
                                         ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
                use_rs1                = 1'b1;
                use_rs2                = 1'b1;
                bundle.ex.alu_ctrl     = alu_op(f3, f7 == F7_ALT);
                bundle.wb.reg_write    = 1'b1;
                bundle.wb.memto_reg    = MEMTOREG_ALU;
            end
            default: legal = 1'b0;
        endcase

        use_rd = bundle.wb.reg_write;
        if (rd == '0) bundle.wb.reg_write = 1'b0;

        // RV32E only has x0..x15; a reference to x16+ in any used field traps.
        if (RV_E && ((use_rs1 && (32'(rs1) >= 16)) || (use_rs2 && (32'(rs2) >= 16)) ||
                     (use_rd && (32'(rd) >= 16))))
            legal = 1'b0;

        if (!legal) begin
            bundle  = CTRL_BUBBLE;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
        illegal = !legal;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decodes in ID and carries the control bundle through
// ID/EX, EX/MEM and MEM/WB with load-use, flush and memory-freeze handling.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INSTR_SIZE = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit RV_E       = 1'b0,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    input  logic [INSTR_SIZE-1:0] id_instr,
    output logic                  id_ready,
    output logic [4:0]            id_immCtrl,
    output logic                  id_illegal,
    input  logic                  ex_branch_taken,
    input  logic                  mem_ready,
    output logic [3:0]            ex_ALUCtrl,
    output logic                  ex_ALUSrcA,
    output logic                  ex_ALUSrcB,
    output logic                  ex_branch,
    output logic [2:0]            ex_branchType,
    output logic [1:0]            ex_jumpType,
    output logic                  mem_memRead,
    output logic                  mem_memWrite,
    output logic [2:0]            mem_memWidth,
    output logic                  wb_regWrite,
    output logic [1:0]            wb_memtoReg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_bundle_t          dec_bundle;
    logic                  dec_illegal;
    logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic                  dec_use_rs1, dec_use_rs2;

    ctrl_decode #(
        .INSTR_SIZE (INSTR_SIZE),
        .REG_ADDR_W (REG_ADDR_W),
        .RV_E       (RV_E)
    ) u_decode (
        .instr    (id_instr),
        .bundle   (dec_bundle),
        .imm_ctrl (id_immCtrl),
        .illegal  (dec_illegal),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .use_rs1  (dec_use_rs1),
        .use_rs2  (dec_use_rs2)
    );

    logic                  ex_v, mem_v, wb_v;
    ctrl_bundle_t          ex_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    mem_ctrl_t             mem_mem_q;
    wb_ctrl_t              mem_wb_q, wb_q;

    logic freeze, flush, load_use, id_fire;

    // Handshake: ID hands over id_instr on a cycle where id_valid && id_ready;
    // id_ready may be high with id_valid low, which simply issues a bubble.
    assign freeze   = mem_v && (mem_mem_q.mem_read || mem_mem_q.mem_write) && !mem_ready;
    assign flush    = ex_branch_taken && !freeze;
    assign load_use = id_valid && ex_v && ex_q.mem.mem_read && (ex_rd_q != '0) &&
                      ((dec_use_rs1 && (dec_rs1 == ex_rd_q)) || (dec_use_rs2 && (dec_rs2 == ex_rd_q))) &&
                      !freeze && !flush;
    assign id_ready   = rstn && !freeze && !load_use;
    assign id_illegal = id_valid && dec_illegal;
    assign id_fire    = id_valid && !dec_illegal && !flush && !load_use;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_v         <= 1'b0;
            mem_v        <= 1'b0;
            wb_v         <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!freeze) begin
                ex_v      <= id_fire;
                ex_q      <= dec_bundle;
                ex_rd_q   <= dec_rd;
                mem_v     <= ex_v;
                mem_mem_q <= ex_q.mem;
                mem_wb_q  <= ex_q.wb;
                mem_rd_q  <= ex_rd_q;
                wb_v      <= mem_v;
                wb_q      <= mem_wb_q;
                wb_rd_q   <= mem_rd_q;
            end else begin
                wb_v <= 1'b0;
            end
            if ((freeze || load_use) && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_ONE;
            if (flush && (flush_count != CNT_MAX))
                flush_count <= flush_count + CNT_ONE;
        end
    end

    // Payload registers are not reset; the valid bits mask them to bubbles.
    ex_ctrl_t  ex_view;
    mem_ctrl_t mem_view;
    wb_ctrl_t  wb_view;

    assign ex_view  = ex_v  ? ex_q.ex   : EX_BUBBLE;
    assign mem_view = mem_v ? mem_mem_q : MEM_BUBBLE;
    assign wb_view  = wb_v  ? wb_q      : WB_BUBBLE;

    assign ex_ALUCtrl    = ex_view.alu_ctrl;
    assign ex_ALUSrcA    = ex_view.alu_src_a;
    assign ex_ALUSrcB    = ex_view.alu_src_b;
    assign ex_branch     = ex_view.branch;
    assign ex_branchType = ex_view.branch_type;
    assign ex_jumpType   = ex_view.jump_type;
    assign mem_memRead   = mem_view.mem_read;
    assign mem_memWrite  = mem_view.mem_write;
    assign mem_memWidth  = mem_view.mem_width;
    assign wb_regWrite   = wb_view.reg_write;
    assign wb_memtoReg   = wb_view.memto_reg;
    assign wb_rd         = wb_v ? wb_rd_q : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, issue, load-use, freeze, flush,
// illegal/RV32E decode and reset during a freeze.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [31:0] I_ADDI_X1 = 32'h00500093;
    localparam logic [31:0] I_NOP     = 32'h00000013;
    localparam logic [31:0] I_ADDI_X4 = 32'h00700213;
    localparam logic [31:0] I_LW      = 32'h0000A103;
    localparam logic [31:0] I_ADD     = 32'h001101B3;
    localparam logic [31:0] I_SW      = 32'h0020A223;
    localparam logic [31:0] I_BAD     = 32'hFFFFFFFF;
    localparam logic [31:0] I_X16     = 32'h01000813;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid, ex_branch_taken, mem_ready;
    logic [31:0] id_instr;
    logic        id_ready, id_illegal;
    logic [4:0]  id_immCtrl;
    logic [3:0]  ex_ALUCtrl;
    logic        ex_ALUSrcA, ex_ALUSrcB, ex_branch;
    logic [2:0]  ex_branchType;
    logic [1:0]  ex_jumpType;
    logic        mem_memRead, mem_memWrite;
    logic [2:0]  mem_memWidth;
    logic        wb_regWrite;
    logic [1:0]  wb_memtoReg;
    logic [4:0]  wb_rd;
    logic [31:0] stall_cycles, flush_count;

    logic        e_id_valid;
    logic [31:0] e_id_instr;
    logic        e_id_ready, e_id_illegal;
    logic [4:0]  e_id_immCtrl;
    logic [3:0]  e_ex_ALUCtrl;
    logic        e_ex_ALUSrcA, e_ex_ALUSrcB, e_ex_branch;
    logic [2:0]  e_ex_branchType;
    logic [1:0]  e_ex_jumpType;
    logic        e_mem_memRead, e_mem_memWrite;
    logic [2:0]  e_mem_memWidth;
    logic        e_wb_regWrite;
    logic [1:0]  e_wb_memtoReg;
    logic [4:0]  e_wb_rd;
    logic [31:0] e_stall_cycles, e_flush_count;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.INSTR_SIZE(32), .REG_ADDR_W(5), .RV_E(1'b0), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
        .id_immCtrl(id_immCtrl), .id_illegal(id_illegal), .ex_branch_taken(ex_branch_taken),
        .mem_ready(mem_ready), .ex_ALUCtrl(ex_ALUCtrl), .ex_ALUSrcA(ex_ALUSrcA),
        .ex_ALUSrcB(ex_ALUSrcB), .ex_branch(ex_branch), .ex_branchType(ex_branchType),
        .ex_jumpType(ex_jumpType), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_memWidth(mem_memWidth), .wb_regWrite(wb_regWrite), .wb_memtoReg(wb_memtoReg),
        .wb_rd(wb_rd), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_ctrl #(.INSTR_SIZE(32), .REG_ADDR_W(5), .RV_E(1'b1), .CNT_W(32)) dut_e (
        .clk(clk), .rstn(rstn), .id_valid(e_id_valid), .id_instr(e_id_instr), .id_ready(e_id_ready),
        .id_immCtrl(e_id_immCtrl), .id_illegal(e_id_illegal), .ex_branch_taken(1'b0),
        .mem_ready(1'b1), .ex_ALUCtrl(e_ex_ALUCtrl), .ex_ALUSrcA(e_ex_ALUSrcA),
        .ex_ALUSrcB(e_ex_ALUSrcB), .ex_branch(e_ex_branch), .ex_branchType(e_ex_branchType),
        .ex_jumpType(e_ex_jumpType), .mem_memRead(e_mem_memRead), .mem_memWrite(e_mem_memWrite),
        .mem_memWidth(e_mem_memWidth), .wb_regWrite(e_wb_regWrite), .wb_memtoReg(e_wb_memtoReg),
        .wb_rd(e_wb_rd), .stall_cycles(e_stall_cycles), .flush_count(e_flush_count)
    );

    // Registered outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        id_instr = I_NOP;
        ex_branch_taken = 1'b0;
        mem_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        id_valid = 1'b1;
        id_instr = I_ADDI_X1;
        ex_branch_taken = 1'b0;
        mem_ready = 1'b1;
        e_id_valid = 1'b0;
        e_id_instr = I_NOP;
        tick();
        tick();
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL reset_id_ready: got %0d want 0", id_ready); end
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("FAIL reset_wb_regWrite: got %0d want 0", wb_regWrite); end
        checks++; if ({mem_memRead, mem_memWrite} !== 2'b00) begin failures++; $display("FAIL reset_mem: got %b want 00", {mem_memRead, mem_memWrite}); end
        checks++; if (ex_ALUCtrl !== ALU_CTRL_ZERO) begin failures++; $display("FAIL reset_ex_alu: got %0d want %0d", ex_ALUCtrl, ALU_CTRL_ZERO); end
        checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
        checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin failures++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count); end
        rstn = 1'b1;
        idle(1);
    endtask

    task automatic test_straight();
        id_valid = 1'b1;
        id_instr = I_ADDI_X1;
        settle();
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL issue_id_ready: got %0d want 1", id_ready); end
        checks++; if (id_immCtrl !== IMM_CTRL_ITYPE) begin failures++; $display("FAIL issue_immCtrl: got %b want %b", id_immCtrl, IMM_CTRL_ITYPE); end
        tick();
        id_valid = 1'b0;
        checks++; if (ex_ALUCtrl !== ALU_CTRL_ADD || ex_ALUSrcB !== 1'b1 || ex_ALUSrcA !== 1'b0) begin failures++; $display("FAIL issue_ex: got alu=%0d b=%0d a=%0d want 1/1/0", ex_ALUCtrl, ex_ALUSrcB, ex_ALUSrcA); end
        tick();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("FAIL issue_wb_early: got %0d want 0", wb_regWrite); end
        tick();
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd1 || wb_memtoReg !== MEMTOREG_ALU) begin failures++; $display("FAIL issue_wb: got we=%0d rd=%0d m2r=%b want 1/1/00", wb_regWrite, wb_rd, wb_memtoReg); end
        tick();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("FAIL issue_wb_after: got %0d want 0", wb_regWrite); end
    endtask

    task automatic test_back_to_back();
        id_valid = 1'b1;
        id_instr = I_ADDI_X1; tick();
        id_instr = I_NOP;     tick();
        id_instr = I_ADDI_X4; tick();
        id_valid = 1'b0;
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd1) begin failures++; $display("FAIL b2b_first: got we=%0d rd=%0d want 1/1", wb_regWrite, wb_rd); end
        tick();
        checks++; if (wb_regWrite !== 1'b0) begin failures++; $display("FAIL b2b_rd0: got %0d want 0", wb_regWrite); end
        tick();
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd4) begin failures++; $display("FAIL b2b_third: got we=%0d rd=%0d want 1/4", wb_regWrite, wb_rd); end
        idle(2);
    endtask

    task automatic test_load_use();
        id_valid = 1'b1;
        id_instr = I_LW;
        tick();
        id_instr = I_ADD;
        settle();
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_stall: got id_ready=%0d want 0", id_ready); end
        tick();
        exp_stall++;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_release: got id_ready=%0d want 1", id_ready); end
        checks++; if (ex_ALUCtrl !== ALU_CTRL_ZERO) begin failures++; $display("FAIL lu_bubble: got alu=%0d want 0", ex_ALUCtrl); end
        checks++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
        checks++; if (mem_memRead !== 1'b1 || mem_memWidth !== 3'b010) begin failures++; $display("FAIL lu_mem: got rd=%0d w=%b want 1/010", mem_memRead, mem_memWidth); end
        tick();
        id_valid = 1'b0;
        checks++; if (ex_ALUCtrl !== ALU_CTRL_ADD || ex_ALUSrcB !== 1'b0) begin failures++; $display("FAIL lu_add_ex: got alu=%0d b=%0d want 1/0", ex_ALUCtrl, ex_ALUSrcB); end
        checks++; if (wb_memtoReg !== MEMTOREG_MEM || wb_regWrite !== 1'b1 || wb_rd !== 5'd2) begin failures++; $display("FAIL lu_wb: got m2r=%b we=%0d rd=%0d want 01/1/2", wb_memtoReg, wb_regWrite, wb_rd); end
        idle(4);
        checks++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL lu_once: got %0d want %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_mem_freeze();
        id_valid = 1'b1;
        id_instr = I_SW;
        tick();
        id_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        id_valid = 1'b1;
        id_instr = I_ADDI_X1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (mem_memWrite !== 1'b1 || mem_memWidth !== 3'b010) begin failures++; $display("FAIL frz_mem_%0d: got we=%0d w=%b want 1/010", i, mem_memWrite, mem_memWidth); end
            checks++; if (id_ready !== 1'b0 || wb_regWrite !== 1'b0) begin failures++; $display("FAIL frz_hold_%0d: got rdy=%0d we=%0d want 0/0", i, id_ready, wb_regWrite); end
            tick();
            exp_stall++;
        end
        mem_ready = 1'b1;
        settle();
        checks++; if (mem_memWrite !== 1'b1 || id_ready !== 1'b1) begin failures++; $display("FAIL frz_release: got we=%0d rdy=%0d want 1/1", mem_memWrite, id_ready); end
        checks++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL frz_cnt: got %0d want %0d", stall_cycles, exp_stall); end
        tick();
        id_valid = 1'b0;
        checks++; if (mem_memWrite !== 1'b0 || wb_regWrite !== 1'b0 || ex_ALUCtrl !== ALU_CTRL_ADD) begin failures++; $display("FAIL frz_after: got we=%0d wbwe=%0d alu=%0d want 0/0/1", mem_memWrite, wb_regWrite, ex_ALUCtrl); end
        idle(4);
    endtask

    task automatic test_flush();
        id_valid = 1'b1;
        id_instr = I_ADDI_X1;
        ex_branch_taken = 1'b1;
        settle();
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL fl_ready: got %0d want 1", id_ready); end
        tick();
        exp_flush++;
        ex_branch_taken = 1'b0;
        id_valid = 1'b0;
        checks++; if (ex_ALUCtrl !== ALU_CTRL_ZERO || ex_ALUSrcB !== 1'b0) begin failures++; $display("FAIL fl_bubble: got alu=%0d b=%0d want 0/0", ex_ALUCtrl, ex_ALUSrcB); end
        checks++; if (flush_count !== 32'(exp_flush)) begin failures++; $display("FAIL fl_cnt: got %0d want %0d", flush_count, exp_flush); end
        idle(3);

        id_valid = 1'b1;
        id_instr = I_SW;
        tick();
        id_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        id_valid = 1'b1;
        id_instr = I_ADDI_X1;
        ex_branch_taken = 1'b1;
        settle();
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL flfrz_ready: got %0d want 0", id_ready); end
        tick();
        exp_stall++;
        checks++; if (flush_count !== 32'(exp_flush) || mem_memWrite !== 1'b1) begin failures++; $display("FAIL flfrz_ignored: got cnt=%0d we=%0d want %0d/1", flush_count, mem_memWrite, exp_flush); end
        mem_ready = 1'b1;
        settle();
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL flfrz_release: got %0d want 1", id_ready); end
        tick();
        exp_flush++;
        checks++; if (flush_count !== 32'(exp_flush) || ex_ALUCtrl !== ALU_CTRL_ZERO) begin failures++; $display("FAIL flfrz_flush: got cnt=%0d alu=%0d want %0d/0", flush_count, ex_ALUCtrl, exp_flush); end
        checks++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL flfrz_stall: got %0d want %0d", stall_cycles, exp_stall); end

        ex_branch_taken = 1'b0;
        id_instr = I_LW;
        tick();
        id_instr = I_ADD;
        ex_branch_taken = 1'b1;
        settle();
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL fllu_ready: got %0d want 1", id_ready); end
        tick();
        exp_flush++;
        checks++; if (stall_cycles !== 32'(exp_stall) || flush_count !== 32'(exp_flush)) begin failures++; $display("FAIL fllu_cnt: got %0d/%0d want %0d/%0d", stall_cycles, flush_count, exp_stall, exp_flush); end
        idle(4);
    endtask

    task automatic test_illegal();
        id_valid = 1'b1;
        id_instr = I_BAD;
        settle();
        checks++; if (id_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag: got %0d want 1", id_illegal); end
        tick();
        id_valid = 1'b0;
        settle();
        checks++; if (ex_ALUCtrl !== ALU_CTRL_ZERO || ex_jumpType !== JUMP_TYPE_NONE || ex_branch !== 1'b0) begin failures++; $display("FAIL ill_bubble: got alu=%0d j=%0d br=%0d want 0/0/0", ex_ALUCtrl, ex_jumpType, ex_branch); end
        checks++; if (id_illegal !== 1'b0) begin failures++; $display("FAIL ill_novalid: got %0d want 0", id_illegal); end
        id_valid = 1'b1;
        id_instr = I_X16;
        e_id_valid = 1'b1;
        e_id_instr = I_X16;
        settle();
        checks++; if (e_id_illegal !== 1'b1) begin failures++; $display("FAIL rve_x16: got %0d want 1", e_id_illegal); end
        checks++; if (id_illegal !== 1'b0) begin failures++; $display("FAIL rvi_x16: got %0d want 0", id_illegal); end
        e_id_instr = I_ADDI_X1;
        settle();
        checks++; if (e_id_illegal !== 1'b0) begin failures++; $display("FAIL rve_x1: got %0d want 0", e_id_illegal); end
        e_id_valid = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_mid_freeze();
        id_valid = 1'b1;
        id_instr = I_SW;
        tick();
        id_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        checks++; if (mem_memWrite !== 1'b0 || id_ready !== 1'b0) begin failures++; $display("FAIL rstfrz_mem: got we=%0d rdy=%0d want 0/0", mem_memWrite, id_ready); end
        checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin failures++; $display("FAIL rstfrz_cnt: got %0d/%0d want 0/0", stall_cycles, flush_count); end
        rstn = 1'b1;
        mem_ready = 1'b1;
        tick();
        checks++; if (mem_memWrite !== 1'b0 || wb_regWrite !== 1'b0) begin failures++; $display("FAIL rstfrz_gone: got we=%0d wbwe=%0d want 0/0", mem_memWrite, wb_regWrite); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_back_to_back();
        test_load_use();
        test_mem_freeze();
        test_flush();
        test_illegal();
        test_reset_mid_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
